ms_sync_relay: RTL

// - Parametrised N-channel master/slave relay: per-channel sync-qualified slave inputs

---
 rtl/ms_relay_pkg.sv | 19 +
 rtl/ms_rr_pick.sv | 36 +++
 rtl/ms_sync_relay.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ms_relay_pkg.sv
// Shared types, mode constants and width helper for the master/slave sync relay.
package ms_relay_pkg;

  // Forwarding FSM: IDLE looks for a pending channel, SEND holds the beat until accepted
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } relayState_e;

  // Capture behaviour selectors for the MODE parameter
  localparam int MODE_LATCH = 0;
  localparam int MODE_ACC   = 1;

  // Channel index width, never narrower than one bit so a single-channel relay still has a port
  function automatic int chIdxWidth(input int numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

endpackage

// File: rtl/ms_rr_pick.sv
// Combinational round-robin picker: finds the first set pend bit starting at rrPtr_i and wrapping.
module ms_rr_pick
  import ms_relay_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CH_W   = chIdxWidth(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pend_i,
  input  logic [CH_W-1:0]   rrPtr_i,
  output logic              any_o,
  output logic [CH_W-1:0]   idx_o
);

  int              cand;
  logic [CH_W-1:0] candIdx;

  // Scan offsets from the far end down to zero so the candidate closest to rrPtr_i wins last
  always_comb begin
    any_o   = 1'b0;
    idx_o   = '0;
    cand    = 0;
    candIdx = '0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      cand = int'(rrPtr_i) + off;
      if (cand >= NUM_CH) begin
        cand = cand - NUM_CH;
      end
      candIdx = CH_W'(cand);
      if (pend_i[candIdx]) begin
        any_o = 1'b1;
        idx_o = candIdx;
      end
    end
  end

endmodule

// File: rtl/ms_sync_relay.sv
// N-channel relay: sync-qualified captures into per-channel registers, always visible on
// s_out_data, and forwarded one at a time round-robin on a valid/ready master stream.
module ms_sync_relay
  import ms_relay_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 32,
  parameter int MODE   = MODE_LATCH,
  parameter int OVF_W  = 8,
  localparam int CH_W  = chIdxWidth(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] s_in_data,
  input  logic [NUM_CH-1:0]        s_in_sync,
  output logic [NUM_CH*DATA_W-1:0] s_out_data,
  output logic [DATA_W-1:0]        m_out_data,
  output logic [CH_W-1:0]          m_out_ch,
  output logic                     m_out_valid,
  input  logic                     m_out_ready,
  output logic [NUM_CH*OVF_W-1:0]  ovf_cnt
);

  relayState_e                   state_q, state_d;
  logic [NUM_CH-1:0][DATA_W-1:0] chData_q, chData_d;
  logic [NUM_CH-1:0]             pend_q, pend_d;
  logic [NUM_CH-1:0][OVF_W-1:0]  ovf_q, ovf_d;
  logic [CH_W-1:0]               rrPtr_q, rrPtr_d;
  logic [DATA_W-1:0]             mData_q, mData_d;
  logic [CH_W-1:0]               mCh_q, mCh_d;
  logic                          mValid_q, mValid_d;

  logic                          pickAny;
  logic [CH_W-1:0]               pickIdx;
  logic                          loadSel;
  logic                          xferDone;
  logic [NUM_CH-1:0]             selVec;

  ms_rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .pend_i  (pend_q),
    .rrPtr_i (rrPtr_q),
    .any_o   (pickAny),
    .idx_o   (pickIdx)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave IDLE when anything is pending, leave SEND once the beat is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pickAny) state_d = SEND;
      SEND:    if (m_out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: load a new beat from IDLE, retire the current beat from SEND
  always_comb begin
    loadSel  = 1'b0;
    xferDone = 1'b0;
    case (state_q)
      IDLE:    loadSel  = pickAny;
      SEND:    xferDone = m_out_ready;
      default: ;
    endcase
  end

  // One-hot of the channel being selected this cycle, used for pend clearing and overrun masking
  always_comb begin
    selVec = '0;
    if (loadSel) begin
      selVec[pickIdx] = 1'b1;
    end
  end

  // Per-channel capture, pending flags and saturating overrun counters; a sync always wins over
  // a same-cycle selection so the freshly captured value is still forwarded later
  always_comb begin
    chData_d = chData_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s_in_sync[i]) begin
        if (MODE == MODE_ACC) begin
          chData_d[i] = chData_q[i] + s_in_data[i*DATA_W +: DATA_W];
        end else begin
          chData_d[i] = s_in_data[i*DATA_W +: DATA_W];
        end
        if (pend_q[i] && !selVec[i] && (ovf_q[i] != {OVF_W{1'b1}})) begin
          ovf_d[i] = ovf_q[i] + OVF_W'(1);
        end
        pend_d[i] = 1'b1;
      end else if (selVec[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  // Master beat: snapshot the pre-capture register on selection, advance the pointer on accept
  always_comb begin
    mData_d  = mData_q;
    mCh_d    = mCh_q;
    mValid_d = mValid_q;
    rrPtr_d  = rrPtr_q;
    if (loadSel) begin
      mData_d  = chData_q[pickIdx];
      mCh_d    = pickIdx;
      mValid_d = 1'b1;
    end
    if (xferDone) begin
      mValid_d = 1'b0;
      rrPtr_d  = (mCh_q == CH_W'(NUM_CH - 1)) ? '0 : mCh_q + CH_W'(1);
    end
  end

  // Datapath registers, all cleared asynchronously so a reset mid-beat drops valid at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chData_q <= '0;
      pend_q   <= '0;
      ovf_q    <= '0;
      rrPtr_q  <= '0;
      mData_q  <= '0;
      mCh_q    <= '0;
      mValid_q <= 1'b0;
    end else begin
      chData_q <= chData_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      rrPtr_q  <= rrPtr_d;
      mData_q  <= mData_d;
      mCh_q    <= mCh_d;
      mValid_q <= mValid_d;
    end
  end

  assign s_out_data  = chData_q;
  assign ovf_cnt     = ovf_q;
  assign m_out_data  = mData_q;
  assign m_out_ch    = mCh_q;
  assign m_out_valid = mValid_q;

endmodule
